// File: rtl/eth_phy_10g_tx_gearbox_pkg.sv
// Shared 10GBASE-R PHY definitions used by both the TX gearbox and the RX aligner.
// Holds sync headers, the error block and gearbox sequence constants.
package eth_phy_10g_tx_gearbox_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] BLOCK_TYPE_ERR = 8'h1E;

    // Control block of type 0x1E carrying eight /E/ codes.
    localparam logic [63:0] ERR_BLOCK = 64'h3C78F1E3C78F1E1E;

    localparam int SEQ_WIDTH = 6;
    localparam logic [SEQ_WIDTH-1:0] SEQ_MAX = 6'd32;

    localparam int WORD_WIDTH  = 64;
    localparam int BLOCK_WIDTH = 66;

    function automatic logic [SEQ_WIDTH-1:0] seq_next(input logic [SEQ_WIDTH-1:0] seq);
        return (seq == SEQ_MAX) ? '0 : seq + 6'd1;
    endfunction

endpackage

// File: rtl/eth_phy_10g_tx_err_insert.sv
// Block source mux: passes the encoder block through, or substitutes the error
// block on underflow and keeps a saturating count of substitutions.
module eth_phy_10g_tx_err_insert
    import eth_phy_10g_tx_gearbox_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [HDR_WIDTH-1:0]  tx_hdr,
    input  logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] blk_data,
    output logic [HDR_WIDTH-1:0]  blk_hdr,
    output logic [CNT_WIDTH-1:0]  err_block_cnt
);

    logic underflow;

    assign underflow = tx_ready && !tx_valid;

    always_comb begin
        blk_data = tx_data;
        blk_hdr  = tx_hdr;
        if (underflow) begin
            blk_data = DATA_WIDTH'(ERR_BLOCK);
            blk_hdr  = HDR_WIDTH'(SYNC_CTRL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_block_cnt <= '0;
        end else if (underflow && (err_block_cnt != {CNT_WIDTH{1'b1}})) begin
            err_block_cnt <= err_block_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66:64 transmit gearbox: packs one 66-bit block per cycle into 64-bit SerDes
// words, pausing block intake for one cycle in every 33 to drain the residual.
module eth_phy_10g_tx_gearbox
    import eth_phy_10g_tx_gearbox_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [HDR_WIDTH-1:0]  i_tx_hdr,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_serdes_tx_data,
    output logic [5:0]            o_tx_seq,
    output logic [CNT_WIDTH-1:0]  o_err_block_cnt
);

    localparam int BLK_W = DATA_WIDTH + HDR_WIDTH;
    localparam int BUF_W = 2 * DATA_WIDTH;

    logic [SEQ_WIDTH-1:0]  seq;
    logic [DATA_WIDTH-1:0] residual;
    logic [DATA_WIDTH-1:0] blk_data;
    logic [HDR_WIDTH-1:0]  blk_hdr;
    logic [BUF_W-1:0]      blk_shifted;
    logic [BUF_W-1:0]      packed_buf;

    // Valid/ready handshake: a block is consumed in every cycle where
    // o_tx_ready is high; if i_tx_valid is low then, the error block is used.
    assign o_tx_ready = (seq != SEQ_MAX);
    assign o_tx_seq   = seq;

    eth_phy_10g_tx_err_insert #(
        .DATA_WIDTH (DATA_WIDTH),
        .HDR_WIDTH  (HDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_err_insert (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (i_tx_data),
        .tx_hdr        (i_tx_hdr),
        .tx_valid      (i_tx_valid),
        .tx_ready      (o_tx_ready),
        .blk_data      (blk_data),
        .blk_hdr       (blk_hdr),
        .err_block_cnt (o_err_block_cnt)
    );

    // Residual holds 2*seq bits; the new block lands right above them.
    always_comb begin
        blk_shifted = BUF_W'({blk_data, blk_hdr}) << {seq[4:0], 1'b0};
        packed_buf  = {{(BUF_W-DATA_WIDTH){1'b0}}, residual} | blk_shifted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq              <= '0;
            residual         <= '0;
            o_serdes_tx_data <= '0;
        end else begin
            seq <= seq_next(seq);
            if (seq == SEQ_MAX) begin
                o_serdes_tx_data <= residual;
                residual         <= '0;
            end else begin
                o_serdes_tx_data <= packed_buf[DATA_WIDTH-1:0];
                residual         <= packed_buf[BUF_W-1:DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Self-checking bench for the TX gearbox: a bit-level FIFO model turns accepted
// blocks into the expected SerDes word stream.
module tb_eth_phy_10g_tx_gearbox;

    localparam logic [63:0] ERR_DATA = 64'h3C78F1E3C78F1E1E;
    localparam logic [1:0]  ERR_HDR  = 2'b01;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tx_data;
    logic [1:0]  tx_hdr;
    logic        tx_valid;
    logic        tx_ready, tx_ready_sat;
    logic [63:0] serdes, serdes_sat;
    logic [5:0]  seq, seq_sat;
    logic [15:0] cnt;
    logic [1:0]  cnt_sat;

    always #5 clk = ~clk;

    eth_phy_10g_tx_gearbox #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .i_tx_data(tx_data), .i_tx_hdr(tx_hdr),
        .i_tx_valid(tx_valid), .o_tx_ready(tx_ready), .o_serdes_tx_data(serdes),
        .o_tx_seq(seq), .o_err_block_cnt(cnt)
    );

    eth_phy_10g_tx_gearbox #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .i_tx_data(tx_data), .i_tx_hdr(tx_hdr),
        .i_tx_valid(tx_valid), .o_tx_ready(tx_ready_sat), .o_serdes_tx_data(serdes_sat),
        .o_tx_seq(seq_sat), .o_err_block_cnt(cnt_sat)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the transmitted bitstream as a queue of bits, oldest first.
    int          model_seq;
    int          model_cnt;
    int          model_cnt_sat;
    bit          stream_q[$];
    logic [63:0] exp_q[$];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_seq = 0;
        model_cnt = 0;
        model_cnt_sat = 0;
        stream_q.delete();
        exp_q.delete();
    endtask

    // Drives one cycle; the block is taken only when the period position is not 32.
    task automatic drive_cycle(input logic v, input logic [63:0] d, input logic [1:0] h);
        logic [65:0] blk;
        logic [63:0] w;
        @(negedge clk);
        tx_valid = v;
        tx_data  = d;
        tx_hdr   = h;
        if (model_seq < 32) begin
            blk = v ? {d, h} : {ERR_DATA, ERR_HDR};
            for (int b = 0; b < 66; b++) stream_q.push_back(blk[b]);
            if (!v) begin
                if (model_cnt < 65535) model_cnt++;
                if (model_cnt_sat < 3) model_cnt_sat++;
            end
        end
        w = '0;
        for (int b = 0; b < 64; b++) if (stream_q.size() > 0) w[b] = stream_q.pop_front();
        exp_q.push_back(w);
        model_seq = (model_seq == 32) ? 0 : model_seq + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (seq !== 6'd0) begin n_err++; $display("FAIL reset_seq: got %0d want 0", seq); end
        n_cmp++; if (serdes !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", serdes); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        n_cmp++; if (cnt_sat !== 2'd0) begin n_err++; $display("FAIL reset_cnt_sat: got %0d want 0", cnt_sat); end
    endtask

    task automatic test_first_word();
        logic [63:0] e;
        do_reset();
        drive_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
        e = exp_q.pop_front();
        n_cmp++; if (serdes !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL first_word: got %h want %h", serdes, 64'hFFFF_FFFF_FFFF_FFFE); end
        n_cmp++; if (serdes !== e) begin n_err++; $display("FAIL first_word_model: got %h want %h", serdes, e); end
    endtask

    task automatic test_incrementing();
        logic [63:0] next_d, e;
        do_reset();
        next_d = 64'd0;
        for (int c = 0; c < 99; c++) begin
            n_cmp++; if (tx_ready !== (model_seq != 32)) begin n_err++; $display("FAIL inc_ready: seq %0d got %b", model_seq, tx_ready); end
            n_cmp++; if (seq !== 6'(model_seq)) begin n_err++; $display("FAIL inc_seq: got %0d want %0d", seq, model_seq); end
            if (model_seq != 32) begin
                drive_cycle(1'b1, next_d, 2'b10);
                next_d++;
            end else begin
                drive_cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 2'($urandom));
            end
            e = exp_q.pop_front();
            n_cmp++; if (serdes !== e) begin n_err++; $display("FAIL inc_word: cycle %0d got %h want %h", c, serdes, e); end
        end
    endtask

    task automatic test_underflow_seq5();
        logic [63:0] e;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            drive_cycle(!(c >= 5 && c <= 7), {$urandom, $urandom}, 2'b10);
            e = exp_q.pop_front();
            n_cmp++; if (serdes !== e) begin n_err++; $display("FAIL uf5_word: cycle %0d got %h want %h", c, serdes, e); end
        end
        n_cmp++; if (cnt !== 16'd3) begin n_err++; $display("FAIL uf5_cnt: got %0d want 3", cnt); end
        n_cmp++; if (cnt !== 16'(model_cnt)) begin n_err++; $display("FAIL uf5_cnt_model: got %0d want %0d", cnt, model_cnt); end
    endtask

    task automatic test_underflow_seq31();
        logic [63:0] e;
        do_reset();
        for (int c = 0; c < 35; c++) begin
            drive_cycle(c != 31, {$urandom, $urandom}, 2'b10);
            e = exp_q.pop_front();
            n_cmp++; if (serdes !== e) begin n_err++; $display("FAIL uf31_word: cycle %0d got %h want %h", c, serdes, e); end
            if (c == 32) begin
                n_cmp++; if (serdes !== ERR_DATA) begin n_err++; $display("FAIL uf31_tail: got %h want %h", serdes, ERR_DATA); end
            end
        end
        n_cmp++; if (cnt !== 16'd1) begin n_err++; $display("FAIL uf31_cnt: got %0d want 1", cnt); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        do_reset();
        while (model_seq != 17) begin
            drive_cycle(1'b1, {$urandom, $urandom}, 2'b10);
            e = exp_q.pop_front();
            n_cmp++; if (serdes !== e) begin n_err++; $display("FAIL mid_pre_word: got %h want %h", serdes, e); end
        end
        n_cmp++; if (seq !== 6'd17) begin n_err++; $display("FAIL mid_seq17: got %0d want 17", seq); end
        do_reset();
        n_cmp++; if (seq !== 6'd0) begin n_err++; $display("FAIL mid_seq0: got %0d want 0", seq); end
        n_cmp++; if (serdes !== 64'd0) begin n_err++; $display("FAIL mid_data0: got %h want 0", serdes); end
        for (int c = 0; c < 40; c++) begin
            drive_cycle(1'b1, {$urandom, $urandom}, 2'b10);
            e = exp_q.pop_front();
            n_cmp++; if (serdes !== e) begin n_err++; $display("FAIL mid_post_word: cycle %0d got %h want %h", c, serdes, e); end
        end
    endtask

    task automatic test_saturation();
        logic [63:0] e;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive_cycle(!(c < 5 || (c >= 8 && c < 10)), {$urandom, $urandom}, 2'b10);
            e = exp_q.pop_front();
            n_cmp++; if (serdes_sat !== e) begin n_err++; $display("FAIL sat_word: cycle %0d got %h want %h", c, serdes_sat, e); end
            n_cmp++; if (cnt_sat !== 2'(model_cnt_sat)) begin n_err++; $display("FAIL sat_cnt_model: cycle %0d got %0d want %0d", c, cnt_sat, model_cnt_sat); end
            if (c == 5) begin
                n_cmp++; if (cnt_sat !== 2'd3) begin n_err++; $display("FAIL sat_cnt5: got %0d want 3", cnt_sat); end
                n_cmp++; if (cnt !== 16'd5) begin n_err++; $display("FAIL sat_wide5: got %0d want 5", cnt); end
            end
        end
        n_cmp++; if (cnt_sat !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", cnt_sat); end
        n_cmp++; if (cnt !== 16'd7) begin n_err++; $display("FAIL sat_wide7: got %0d want 7", cnt); end
        n_cmp++; if (tx_ready_sat !== tx_ready || seq_sat !== seq) begin n_err++; $display("FAIL sat_phase: seq %0d want %0d", seq_sat, seq); end
    endtask

    task automatic test_random();
        logic [63:0] e;
        do_reset();
        for (int c = 0; c < 140; c++) begin
            n_cmp++; if (tx_ready !== (model_seq != 32)) begin n_err++; $display("FAIL rnd_ready: seq %0d got %b", model_seq, tx_ready); end
            drive_cycle($urandom_range(0, 9) != 0, {$urandom, $urandom}, 2'($urandom));
            e = exp_q.pop_front();
            n_cmp++; if (serdes !== e) begin n_err++; $display("FAIL rnd_word: cycle %0d got %h want %h", c, serdes, e); end
        end
        n_cmp++; if (cnt !== 16'(model_cnt)) begin n_err++; $display("FAIL rnd_cnt: got %0d want %0d", cnt, model_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        tx_hdr = 2'b10;
        test_reset();
        test_first_word();
        test_incrementing();
        test_underflow_seq5();
        test_underflow_seq31();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_tx_gearbox.md
# eth_phy_10g_tx_gearbox

Transmit-side 66:64 gearbox for the 10GBASE-R PHY. It accepts one 66-bit block (2-bit sync header plus 64-bit payload) per accepted cycle and packs the bitstream into 64-bit SerDes words, one per clock. It throttles the upstream encoder with a ready signal that drops for one cycle in every 33. It feeds the same 64-bit SerDes lane whose receive side is block-aligned by the RX frame aligner. It also substitutes an error block when the encoder underflows.

## Interface
Parameters:
- DATA_WIDTH, 64, payload width; only 64 is supported.
- HDR_WIDTH, 2, sync header width.
- CNT_WIDTH, 16, width of the error-block counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_tx_data  in  64  block payload, transmitted after the header.
- i_tx_hdr  in  2  sync header; bit 0 is transmitted first. 2'b10 = data, 2'b01 = control.
- i_tx_valid  in  1  block present on i_tx_data/i_tx_hdr.
- o_tx_ready  out  1  gearbox accepts a block this cycle.
- o_serdes_tx_data  out  64  SerDes word; bit 0 is transmitted first.
- o_tx_seq  out  6  current sequence position, 0..32.
- o_err_block_cnt  out  CNT_WIDTH  saturating count of substituted error blocks.

## Operation
- seq counter runs 0..32 and wraps 32→0. It advances by 1 every cycle out of reset, independent of i_tx_valid.
- o_tx_ready is a combinational decode: o_tx_ready = (seq != 32).
- Residual buffer (128 bits) holds 2·seq untransmitted bits, with the oldest bit at the LSB.
- Cycle with seq = k < 32: the gearbox always consumes one block B = {data, hdr}, with hdr at bits [1:0].
  - Form C = residual | (B << 2k).
  - Next output word = C[63:0].
  - New residual = C >> 64, which is 2k+2 bits.
- Cycle with seq = 32: no block is consumed. The next output word is residual[63:0], and the residual is cleared.
- Accounting: 32 blocks × 66 bits = 33 words × 64 bits. No bits are lost or duplicated.
- Underflow (o_tx_ready=1 and i_tx_valid=0): the gearbox substitutes the error block.
  - Error block: hdr = 2'b01, data = 64'h3C78F1E3C78F1E1E (type 0x1E, eight /E/ codes).
  - o_err_block_cnt increments and saturates at all-ones.
- i_tx_valid and the block inputs are ignored when o_tx_ready=0. No stall or back-pressure exists beyond the ready pattern.
- Header contents are not checked. Blocks with 2'b00 or 2'b11 headers pass through unchanged.

## Timing
- Reset values: seq=0, residual=0, o_serdes_tx_data=0, o_err_block_cnt=0. o_tx_ready is therefore 1 in the first cycle after reset.
- Latency: the first bits of a block accepted in cycle t appear on o_serdes_tx_data in cycle t+1. The output is registered.
- o_tx_ready low pattern: 32 cycles high, 1 cycle low, repeating, phase-locked to seq.
- Reset mid-sequence: the residual is discarded, the partial block is lost and seq restarts at 0. Downstream must regain block lock.
- Underflow at seq=31: the error block contributes its final 64 bits to the seq=32 word, exactly like a normal block.
- Simultaneous saturation and underflow: the counter holds at max. No wrap.

## Structure
- Shared PHY package, common with the RX path, holds:
  - SYNC_DATA = 2'b10 and SYNC_CTRL = 2'b01;
  - BLOCK_TYPE_ERR = 8'h1E;
  - the ERR_BLOCK payload constant;
  - SEQ_MAX = 32.
- One natural sub-module: eth_phy_10g_tx_err_insert. It is the valid/ready mux that selects the block or the error block and maintains the saturating counter. The shift/pack datapath and the seq counter live in the top.

## Test plan
- Reset release, continuous valid blocks with hdr=2'b10 and data = incrementing 64'h0,1,2…:
  - o_tx_ready is low only when o_tx_seq=32.
  - The concatenated output bitstream equals the concatenated 66-bit blocks bit-exact over 3 full 33-cycle periods.
- First word after reset with block {data=64'hFFFF_FFFF_FFFF_FFFF, hdr=2'b10} → o_serdes_tx_data = 64'hFFFF_FFFF_FFFF_FFFE one cycle later.
- i_tx_valid=0 for 3 cycles at seq=5:
  - Three error blocks appear bit-exact in the stream.
  - o_err_block_cnt=3.
- Underflow at seq=31 → the seq=32 output word is the upper 64 bits of the error block.
- rst pulse at seq=17:
  - The next cycle has seq=0 and the output is 0.
  - The stream restarts aligned to a fresh block boundary.
- CNT_WIDTH=2 with 5 underflows → o_err_block_cnt = 3, held.
- Loopback into the RX frame aligner with random data blocks → RX block lock asserts and recovered hdr/data match the transmitted blocks.
